rx_lane_scheduler: RTL and testbench

Two-lane receive controller placed after the per-lane serial-to-parallel converters. It waits for both lanes to report active and aligns them on a common byte boundary. It then buffers each lane's recovered bytes and re-interleaves them into a single byte stream in strict lane0/lane1 order, with a ready/valid handshake to the downstream consumer. It also supervises the link: it detects lane drop, alignment timeout and buffer overflow, and reports link state and error flags.

---
 rtl/rx_lane_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_rx_lane_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_lane_scheduler.sv
// rtl/rx_lane_scheduler.sv - two-lane receive aligner, buffer and byte re-interleaver
// Lane FIFOs are combinational-read so data_out follows registered FIFO state only.

module rx_lane_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;

  // Caller never pushes into a full FIFO without a matching pop; when full,
  // wr_q == rd_q and the old head has already been read out combinationally.
  always_ff @(posedge clk_4f) begin
    if (push_i && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (!reset || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
endmodule

module rx_lane_scheduler #(
  parameter int DEPTH         = 4,
  parameter int ALIGN_TIMEOUT = 64
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [7:0]  lane0_data,
  input  logic [7:0]  lane1_data,
  input  logic        lane0_valid,
  input  logic        lane1_valid,
  input  logic        lane0_active,
  input  logic        lane1_active,
  input  logic        ready_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        link_up,
  output logic [1:0]  state,
  output logic        overflow_err,
  output logic        timeout_err,
  output logic [15:0] byte_cnt
);
  localparam int TW = $clog2(ALIGN_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(ALIGN_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          nxt_q, nxt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   byte_cnt_q, byte_cnt_d;
  logic          overflow_q, overflow_d;
  logic          timeout_q, timeout_d;
  logic          link_up_q;

  logic       both_active, any_active, in_run, in_align;
  logic       align_hit, xfer, pop0, pop1, push0, push1, ovf0, ovf1, flush;
  logic [7:0] head0, head1;
  logic       full0, full1, empty0, empty1;
  logic [TW-1:0] timer_inc;

  assign both_active = lane0_active && lane1_active;
  assign any_active  = lane0_active || lane1_active;
  assign in_run      = (state_q == ST_RUN);
  assign in_align    = (state_q == ST_ALIGN);
  assign timer_inc   = timer_q + 1'b1;

  assign valid_out = in_run && (nxt_q ? !empty1 : !empty0);
  assign data_out  = valid_out ? (nxt_q ? head1 : head0) : 8'h00;
  assign xfer      = valid_out && ready_in;
  assign pop0      = xfer && !nxt_q;
  assign pop1      = xfer && nxt_q;

  assign align_hit = in_align && both_active && lane0_valid && lane1_valid;
  assign push0     = align_hit || (in_run && lane0_valid);
  assign push1     = align_hit || (in_run && lane1_valid);
  assign ovf0      = in_run && lane0_valid && full0 && !pop0;
  assign ovf1      = in_run && lane1_valid && full1 && !pop1;

  // Flush on the edge that leaves RUN so valid_out is low right after it.
  assign flush = (state_q == ST_IDLE) || (state_q == ST_ERR) ||
                 (in_run && (!both_active || ovf0 || ovf1));

  rx_lane_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk_4f  (clk_4f),
    .reset   (reset),
    .flush_i (flush),
    .push_i  (push0),
    .data_i  (lane0_data),
    .pop_i   (pop0),
    .head_o  (head0),
    .full_o  (full0),
    .empty_o (empty0)
  );

  rx_lane_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk_4f  (clk_4f),
    .reset   (reset),
    .flush_i (flush),
    .push_i  (push1),
    .data_i  (lane1_data),
    .pop_i   (pop1),
    .head_o  (head1),
    .full_o  (full1),
    .empty_o (empty1)
  );

  always_comb begin
    state_d    = state_q;
    nxt_d      = nxt_q;
    timer_d    = timer_q;
    byte_cnt_d = xfer ? byte_cnt_q + 16'd1 : byte_cnt_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        nxt_d   = 1'b0;
        if (both_active) state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        timer_d = timer_inc;
        nxt_d   = 1'b0;
        // Lane drop wins over alignment, alignment wins over timeout.
        if (!both_active) begin
          state_d = ST_IDLE;
        end else if (lane0_valid && lane1_valid) begin
          state_d = ST_RUN;
        end else if (timer_inc == TIMEOUT_V) begin
          timeout_d = 1'b1;
          state_d   = ST_ERR;
        end
      end
      ST_RUN: begin
        if (!both_active) begin
          state_d = ST_IDLE;
          nxt_d   = 1'b0;
        end else if (ovf0 || ovf1) begin
          overflow_d = 1'b1;
          state_d    = ST_ERR;
          nxt_d      = 1'b0;
        end else if (xfer) begin
          nxt_d = !nxt_q;
        end
      end
      ST_ERR: begin
        nxt_d = 1'b0;
        if (!any_active) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      nxt_q      <= 1'b0;
      timer_q    <= '0;
      byte_cnt_q <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      link_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      nxt_q      <= nxt_d;
      timer_q    <= timer_d;
      byte_cnt_q <= byte_cnt_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      link_up_q  <= (state_d == ST_RUN);
    end
  end

  assign link_up      = link_up_q;
  assign state        = state_q;
  assign overflow_err = overflow_q;
  assign timeout_err  = timeout_q;
  assign byte_cnt     = byte_cnt_q;
endmodule

// File: tb/tb_rx_lane_scheduler.sv
// tb/tb_rx_lane_scheduler.sv - directed self-checking bench for rx_lane_scheduler

module tb_rx_lane_scheduler;
  logic        clk_4f = 1'b0;
  logic        reset;
  logic [7:0]  lane0_data, lane1_data;
  logic        lane0_valid, lane1_valid;
  logic        lane0_active, lane1_active;
  logic        ready_in;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        link_up;
  logic [1:0]  state;
  logic        overflow_err;
  logic        timeout_err;
  logic [15:0] byte_cnt;

  int n_checks = 0;
  int n_errors = 0;

  rx_lane_scheduler #(.DEPTH(4), .ALIGN_TIMEOUT(64)) dut (
    .clk_4f       (clk_4f),
    .reset        (reset),
    .lane0_data   (lane0_data),
    .lane1_data   (lane1_data),
    .lane0_valid  (lane0_valid),
    .lane1_valid  (lane1_valid),
    .lane0_active (lane0_active),
    .lane1_active (lane1_active),
    .ready_in     (ready_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .link_up      (link_up),
    .state        (state),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err),
    .byte_cnt     (byte_cnt)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic do_reset();
    lane0_data = 8'h00; lane1_data = 8'h00;
    lane0_valid = 1'b0; lane1_valid = 1'b0;
    lane0_active = 1'b0; lane1_active = 1'b0;
    ready_in = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic bring_up();
    lane0_active = 1'b1; lane1_active = 1'b1;
    step();
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    lane0_data = a; lane1_data = b;
    lane0_valid = 1'b1; lane1_valid = 1'b1;
    step();
    lane0_valid = 1'b0; lane1_valid = 1'b0;
  endtask

  logic [7:0] exp_stream [4];

  initial begin
    exp_stream[0] = 8'hA0; exp_stream[1] = 8'hB0;
    exp_stream[2] = 8'hA1; exp_stream[3] = 8'hB1;

    // Reset values and basic bring-up with ordered interleave
    do_reset();
    chk_eq("rst_state", state, 2'd0);
    chk_eq("rst_valid", valid_out, 1'b0);
    chk_eq("rst_data", data_out, 8'h00);
    chk_eq("rst_link", link_up, 1'b0);
    chk_eq("rst_ovf", overflow_err, 1'b0);
    chk_eq("rst_tmo", timeout_err, 1'b0);
    chk_eq("rst_cnt", byte_cnt, 16'd0);
    step();
    chk_eq("idle_hold", state, 2'd0);
    ready_in = 1'b1;
    bring_up();
    chk_eq("up_align", state, 2'd1);
    chk_eq("up_align_link", link_up, 1'b0);
    lane0_data = 8'hA0; lane1_data = 8'hB0;
    lane0_valid = 1'b1; lane1_valid = 1'b1;
    step();
    chk_eq("up_run", state, 2'd2);
    chk_eq("up_link", link_up, 1'b1);
    chk_eq("up_valid", valid_out, 1'b1);
    lane0_data = 8'hA1; lane1_data = 8'hB1;
    for (int i = 0; i < 4; i++) begin
      chk_eq($sformatf("up_byte%0d", i), data_out, exp_stream[i]);
      step();
      lane0_valid = 1'b0; lane1_valid = 1'b0;
    end
    chk_eq("up_drained", valid_out, 1'b0);
    chk_eq("up_drained_data", data_out, 8'h00);
    chk_eq("up_cnt", byte_cnt, 16'd4);

    // Misaligned start: lane0-only bytes are discarded
    do_reset();
    ready_in = 1'b1;
    bring_up();
    lane0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lane0_data = 8'h11 + 8'(i);
      step();
    end
    chk_eq("mis_still_align", state, 2'd1);
    push_pair(8'h21, 8'h31);
    chk_eq("mis_first", data_out, 8'h21);
    step();
    chk_eq("mis_second", data_out, 8'h31);
    step();
    chk_eq("mis_cnt", byte_cnt, 16'd2);

    // Overflow under backpressure: the 5th push into a lane FIFO
    do_reset();
    bring_up();
    push_pair(8'h01, 8'h02);
    lane0_valid = 1'b1; lane1_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk_eq("ovf_full_state", state, 2'd2);
    chk_eq("ovf_full_flag", overflow_err, 1'b0);
    chk_eq("ovf_full_head", data_out, 8'h01);
    step();
    lane0_valid = 1'b0; lane1_valid = 1'b0;
    chk_eq("ovf_flag", overflow_err, 1'b1);
    chk_eq("ovf_state", state, 2'd3);
    chk_eq("ovf_valid", valid_out, 1'b0);
    chk_eq("ovf_link", link_up, 1'b0);
    step();
    chk_eq("ovf_err_hold", state, 2'd3);
    lane0_active = 1'b0; lane1_active = 1'b0;
    step();
    chk_eq("ovf_to_idle", state, 2'd0);
    chk_eq("ovf_sticky", overflow_err, 1'b1);

    // Full FIFO0 with simultaneous push and pop stays full without error
    do_reset();
    bring_up();
    push_pair(8'h50, 8'h60);
    lane0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lane0_data = 8'h51 + 8'(i);
      step();
    end
    chk_eq("pp_head", data_out, 8'h50);
    lane0_data = 8'h54;
    ready_in = 1'b1;
    step();
    chk_eq("pp_no_err", overflow_err, 1'b0);
    chk_eq("pp_state", state, 2'd2);
    chk_eq("pp_next", data_out, 8'h60);
    chk_eq("pp_cnt", byte_cnt, 16'd1);
    ready_in = 1'b0;
    lane0_data = 8'h55;
    step();
    lane0_valid = 1'b0;
    chk_eq("pp_still_full", overflow_err, 1'b1);

    // Alignment timeout
    do_reset();
    bring_up();
    for (int i = 0; i < 63; i++) step();
    chk_eq("tmo_before", state, 2'd1);
    chk_eq("tmo_before_flag", timeout_err, 1'b0);
    step();
    chk_eq("tmo_state", state, 2'd3);
    chk_eq("tmo_flag", timeout_err, 1'b1);
    lane0_active = 1'b0; lane1_active = 1'b0;
    step();
    chk_eq("tmo_idle", state, 2'd0);
    chk_eq("tmo_sticky", timeout_err, 1'b1);
    do_reset();
    chk_eq("tmo_cleared", timeout_err, 1'b0);

    // Lane drop mid-stream, then reset mid-stream
    bring_up();
    push_pair(8'h41, 8'h51);
    push_pair(8'h42, 8'h52);
    chk_eq("drop_head", data_out, 8'h41);
    ready_in = 1'b1;
    lane1_active = 1'b0;
    step();
    chk_eq("drop_state", state, 2'd0);
    chk_eq("drop_valid", valid_out, 1'b0);
    chk_eq("drop_cnt", byte_cnt, 16'd1);
    lane1_active = 1'b1;
    step();
    chk_eq("drop_realign", state, 2'd1);
    push_pair(8'h61, 8'h71);
    chk_eq("drop_flushed", data_out, 8'h61);
    step();
    chk_eq("drop_next", data_out, 8'h71);
    chk_eq("drop_cnt2", byte_cnt, 16'd2);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_eq("mrst_state", state, 2'd0);
    chk_eq("mrst_valid", valid_out, 1'b0);
    chk_eq("mrst_data", data_out, 8'h00);
    chk_eq("mrst_link", link_up, 1'b0);
    chk_eq("mrst_cnt", byte_cnt, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
